// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic datapath: multiplier FSM encoding
// and the multiply mode constants also used by the control unit.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } mult_state_e;

  localparam logic MUL_UNSIGNED = 1'b0;
  localparam logic MUL_SIGNED   = 1'b1;

endpackage

// File: rtl/mult_addsub.sv
// Combinational WIDTH+1 adder/subtractor: a +/- m, with m zero-extended
// in unsigned mode and sign-extended in signed mode.
module mult_addsub
  import arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] m_i,
  input  logic             mode_i,
  input  logic             sub_i,
  output logic [WIDTH:0]   sum_o
);

  logic [WIDTH:0] m_ext;

  always_comb begin
    m_ext = (mode_i == MUL_SIGNED) ? {m_i[WIDTH-1], m_i} : {1'b0, m_i};
    sum_o = sub_i ? (a_i - m_ext) : (a_i + m_ext);
  end

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle multiplier: unsigned shift-add or signed radix-2 Booth,
// one ADD and one SHIFT cycle per multiplier bit, DONE pulse at the end.
module seq_multiplier
  import arith_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               mult_en_i,
  input  logic               mul_sel_i,
  input  logic [WIDTH-1:0]   a_in_i,
  input  logic [WIDTH-1:0]   b_in_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o,
  output logic [1:0]         state_o
);

  mult_state_e        state_q, state_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic               q1_q, q1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic               add_en, sub_en;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shift_a;
  logic [WIDTH-1:0]   shift_q;

  mult_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a_i    (a_q),
    .m_i    (m_q),
    .mode_i (mode_q),
    .sub_i  (sub_en),
    .sum_o  (sum)
  );

  // Booth recodes {Q[0], Q_1}; shift-add only looks at Q[0].
  always_comb begin
    add_en = 1'b0;
    sub_en = 1'b0;
    if (mode_q == MUL_UNSIGNED) begin
      add_en = q_q[0];
    end else begin
      add_en = ({q_q[0], q1_q} == 2'b01);
      sub_en = ({q_q[0], q1_q} == 2'b10);
    end
    shift_a = {(mode_q == MUL_SIGNED) ? a_q[WIDTH] : 1'b0, a_q[WIDTH:1]};
    shift_q = {a_q[0], q_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (mult_en_i) begin
          m_d     = a_in_i;
          q_d     = b_in_i;
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = CNT_W'(WIDTH);
          mode_d  = mul_sel_i;
          state_d = ADD;
        end
      end
      ADD: begin
        if (add_en || sub_en) a_d = sum;
        state_d = SHIFT;
      end
      SHIFT: begin
        a_d   = shift_a;
        q_d   = shift_q;
        q1_d  = q_q[0];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          prod_d  = {shift_a[WIDTH-1:0], shift_q};
          state_d = DONE;
        end else begin
          state_d = ADD;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort wins over everything, including a start request in IDLE.
    if (clr_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= MUL_UNSIGNED;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      prod_q  <= prod_d;
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign product_o = prod_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and randomized bench for seq_multiplier against an arithmetic
// reference model; outputs are sampled on the falling clock edge.
module tb_seq_multiplier;
  import arith_pkg::*;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;
  localparam int LAT   = 2 * WIDTH;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clr;
  logic               mult_en;
  logic               mul_sel;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic [1:0]         state;

  int n_tests = 0;
  int n_fail  = 0;

  seq_multiplier #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clr_i     (clr),
    .mult_en_i (mult_en),
    .mul_sel_i (mul_sel),
    .a_in_i    (a_in),
    .b_in_i    (b_in),
    .busy_o    (busy),
    .done_o    (done),
    .product_o (product),
    .state_o   (state)
  );

  always #5 clk = ~clk;

  function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic sel);
    longint sa, sb, p;
    if (sel) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({1'b0, a});
      sb = longint'({1'b0, b});
    end
    p = sa * sb;
    return p[2*WIDTH-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sel);
    @(negedge clk);
    a_in    = a;
    b_in    = b;
    mul_sel = sel;
    mult_en = 1'b1;
    @(negedge clk);
    mult_en = 1'b0;
  endtask

  // Counts falling edges after acceptance until DONE; 0 means timeout.
  task automatic wait_done(input int already, output int cyc, output logic busy_ok);
    cyc     = 0;
    busy_ok = 1'b1;
    for (int k = already + 1; k <= already + 100; k++) begin
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic sel);
    int   cyc;
    logic bok;
    start_op(a, b, sel);
    a_in    = WIDTH'($urandom_range(0, 65535));
    b_in    = WIDTH'($urandom_range(0, 65535));
    mul_sel = ~sel;
    wait_done(0, cyc, bok);
    check({tag, "_latency"}, 64'(cyc), 64'(LAT));
    check({tag, "_busy"}, 64'(bok), 64'(1));
    check({tag, "_product"}, 64'(product), 64'(model(a, b, sel)));
    @(negedge clk);
    check({tag, "_idle_after"}, 64'({busy, done}), 64'(0));
  endtask

  initial begin
    int             cyc, nd;
    logic           bok;
    logic [2*WIDTH-1:0] prior;
    logic [WIDTH-1:0]   ra, rb;
    logic               rs;

    rst_n = 1'b0; clr = 1'b0; mult_en = 1'b0; mul_sel = 1'b0;
    a_in = '0; b_in = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_product", 64'(product), 64'(0));
    check("reset_state", 64'(state), 64'(IDLE));
    rst_n = 1'b1;

    run_op("u_ffff_ffff", 16'hFFFF, 16'hFFFF, MUL_UNSIGNED);
    check("u_ffff_const", 64'(product), 64'h0000_0000_FFFE_0001);
    run_op("s_m3_5", 16'hFFFD, 16'h0005, MUL_SIGNED);
    check("s_m3_5_const", 64'(product), 64'h0000_0000_FFFF_FFF1);
    run_op("s_8000_8000", 16'h8000, 16'h8000, MUL_SIGNED);
    check("s_8000_8000_const", 64'(product), 64'h0000_0000_4000_0000);
    run_op("s_8000_1", 16'h8000, 16'h0001, MUL_SIGNED);
    check("s_8000_1_const", 64'(product), 64'h0000_0000_FFFF_8000);
    run_op("u_zero", 16'h0000, 16'h1234, MUL_UNSIGNED);
    run_op("s_zero", 16'h8001, 16'h0000, MUL_SIGNED);
    run_op("s_neg_neg", 16'hFFFF, 16'hFFFF, MUL_SIGNED);

    for (int i = 0; i < 16; i++) begin
      ra = WIDTH'($urandom_range(0, 65535));
      rb = WIDTH'($urandom_range(0, 65535));
      rs = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", i), ra, rb, rs);
    end

    // Start request while busy is dropped.
    start_op(16'h1234, 16'h00FF, MUL_UNSIGNED);
    repeat (9) @(negedge clk);
    a_in = 16'hAAAA; b_in = 16'h5555; mul_sel = MUL_SIGNED; mult_en = 1'b1;
    @(negedge clk);
    mult_en = 1'b0;
    wait_done(10, cyc, bok);
    check("repulse_latency", 64'(cyc), 64'(LAT));
    check("repulse_product", 64'(product), 64'(model(16'h1234, 16'h00FF, MUL_UNSIGNED)));
    count_dones(40, nd);
    check("repulse_no_second_done", 64'(nd), 64'(0));
    check("repulse_idle", 64'(busy), 64'(0));

    // MULT_EN held through DONE: next start is taken on the IDLE cycle after it.
    @(negedge clk);
    a_in = 16'h0102; b_in = 16'h0304; mul_sel = MUL_UNSIGNED; mult_en = 1'b1;
    @(negedge clk);
    wait_done(0, cyc, bok);
    check("hold_first_latency", 64'(cyc), 64'(LAT));
    a_in = 16'hFFF0; b_in = 16'h0011; mul_sel = MUL_SIGNED;
    @(negedge clk);
    check("hold_idle_gap", 64'(busy), 64'(0));
    @(negedge clk);
    mult_en = 1'b0;
    check("hold_restart_busy", 64'(busy), 64'(1));
    a_in = '0; b_in = '0;
    wait_done(0, cyc, bok);
    check("hold_second_latency", 64'(cyc), 64'(LAT));
    check("hold_second_product", 64'(product), 64'(model(16'hFFF0, 16'h0011, MUL_SIGNED)));
    @(negedge clk);

    // CLR mid-operation.
    run_op("pre_clr", 16'hFFFF, 16'hFFFF, MUL_UNSIGNED);
    prior = product;
    start_op(16'h0007, 16'h0009, MUL_UNSIGNED);
    repeat (14) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_busy_low", 64'(busy), 64'(0));
    count_dones(40, nd);
    check("clr_no_done", 64'(nd), 64'(0));
    check("clr_product_kept", 64'(product), 64'(prior));

    // CLR and MULT_EN together in IDLE: no start.
    @(negedge clk);
    clr = 1'b1; mult_en = 1'b1; a_in = 16'h0003; b_in = 16'h0003;
    @(negedge clk);
    clr = 1'b0; mult_en = 1'b0;
    check("clr_start_busy", 64'(busy), 64'(0));
    count_dones(40, nd);
    check("clr_start_no_done", 64'(nd), 64'(0));
    check("clr_start_product", 64'(product), 64'(prior));

    // Asynchronous reset between edges mid-SHIFT.
    start_op(16'h00FF, 16'h00FF, MUL_UNSIGNED);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_product", 64'(product), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_7x6", 16'h0007, 16'h0006, MUL_UNSIGNED);
    check("post_rst_const", 64'(product), 64'h0000_0000_0000_002A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
